// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 buffered demultiplexer.
package demux_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NCH       = 4;

    typedef logic [1:0] ch_idx_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel of the demultiplexer: a single-entry register with a
// full flag. A load and a drain on the same edge overwrite the entry and keep
// it full, so a channel that is read every cycle can take a new word every
// cycle.
// Optional feature: define DEMUX_CNT_EN to add an 8-bit wrapping count of
// delivered words.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             ready,
`ifdef DEMUX_CNT_EN
    output logic [7:0]       cnt,
`endif
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic [WIDTH-1:0] data_p0;
    logic             full_p0;
    logic             drain;

    // ready only matters while the entry holds a word
    assign drain = full_p0 & ready;

    // Entry register: a load wins over a drain, which replaces the word in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0 <= '0;
            full_p0 <= 1'b0;
        end else if (load) begin
            data_p0 <= in_data;
            full_p0 <= 1'b1;
        end else if (drain) begin
            full_p0 <= 1'b0;
        end
    end

`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_p0;

    // Delivered-word counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= 8'd0;
        end else if (drain) begin
            cnt_p0 <= cnt_p0 + 8'd1;
        end
    end

    assign cnt = cnt_p0;
`endif

    assign data = data_p0;
    assign full = full_p0;

endmodule

// File: rtl/demux1t4_buf.sv
// 1-to-4 demultiplexer with a one-word buffer per output channel.
// A word on in_data is steered to the channel chosen by s. Each channel has
// its own valid/ready handshake, so a stalled channel never blocks the others.
// Optional feature: define DEMUX_CNT_EN to add the cnt output holding four
// 8-bit delivered-word counters, channel k in bits [8k+7:8k].
module demux1t4_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  ch_idx_t          s,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    input  logic [NCH-1:0]   out_ready,
`ifdef DEMUX_CNT_EN
    output logic [NCH*8-1:0] cnt,
`endif
    output logic [NCH-1:0]   out_valid
);

    logic [NCH-1:0]   full;
    logic [NCH-1:0]   load;
    logic [WIDTH-1:0] data [NCH];
    logic             accept;

    // The selected slot can take a word if it is empty or being drained now.
    assign in_ready = ~full[s] | out_ready[s];
    assign accept   = in_valid & in_ready;

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        assign load[k] = accept & (s == ch_idx_t'(k));

        demux_slot #(
            .WIDTH   (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load[k]),
            .in_data (in_data),
            .ready   (out_ready[k]),
`ifdef DEMUX_CNT_EN
            .cnt     (cnt[8*k +: 8]),
`endif
            .data    (data[k]),
            .full    (full[k])
        );
    end

    assign out_valid = full;
    assign o0        = data[0];
    assign o1        = data[1];
    assign o2        = data[2];
    assign o3        = data[3];

endmodule

// File: tb/tb_demux1t4_buf.sv
// Bench for demux1t4_buf: directed scenarios plus randomized traffic, checked
// against a per-channel occupancy model kept in plain arrays.
module tb_demux1t4_buf;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   s;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] o0, o1, o2, o3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
`ifdef DEMUX_CNT_EN
    logic [31:0]  cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each channel holds and how many words it delivered.
    bit           m_full  [4];
    logic [W-1:0] m_data  [4];
    int           m_deliv [4];

    always #5 clk = ~clk;

    demux1t4_buf #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (s),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .out_ready (out_ready),
`ifdef DEMUX_CNT_EN
        .cnt       (cnt),
`endif
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] out_of(input int k);
        case (k)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            default: return o3;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k]  = 1'b0;
            m_data[k]  = '0;
            m_deliv[k] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), out_valid[k], m_full[k]);
            chk($sformatf("%s_o%0d", tag, k), out_of(k), m_data[k]);
`ifdef DEMUX_CNT_EN
            chk($sformatf("%s_cnt%0d", tag, k), cnt[8*k +: 8], m_deliv[k] % 256);
`endif
        end
    endtask

    // One clock of traffic: drive at negedge, check in_ready, then after the
    // rising edge advance the model and compare all outputs.
    task automatic step(input logic [1:0] ss, input logic [W-1:0] d, input logic v,
                        input logic [3:0] rdy, input string tag);
        bit exp_rdy;
        bit acc;
        @(negedge clk);
        s         = ss;
        in_data   = d;
        in_valid  = v;
        out_ready = rdy;
        #1;
        exp_rdy = 1'b0;
        if (!$isunknown(ss)) begin
            exp_rdy = !m_full[ss] || rdy[ss];
            chk({tag, "_in_ready"}, in_ready, exp_rdy);
        end
        acc = v && exp_rdy;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (m_full[k] && rdy[k]) begin
                m_deliv[k]++;
                m_full[k] = 1'b0;
            end
        end
        if (acc) begin
            m_full[ss] = 1'b1;
            m_data[ss] = d;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst       = 1'b1;
        s         = 2'd0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        model_reset();

        // Reset values before any clock edge has occurred
        #1;
        chk("rst_out_valid", out_valid, 4'b0000);
        chk("rst_o0", o0, 32'h0);
        chk("rst_o3", o3, 32'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single word to channel 2, consumer always ready
        step(2'd2, 32'hDEADBEEF, 1'b1, 4'b1111, "ch2_send");
        chk("ch2_vld_one", out_valid, 4'b0100);
        chk("ch2_data", o2, 32'hDEADBEEF);
        step(2'd0, 32'h0, 1'b0, 4'b1111, "ch2_after");
        chk("ch2_vld_gone", out_valid, 4'b0000);

        // Stalled channel 1 blocks only itself
        step(2'd1, 32'hA1A1A1A1, 1'b1, 4'b0000, "ch1_first");
        step(2'd1, 32'hB2B2B2B2, 1'b1, 4'b0000, "ch1_blocked");
        chk("ch1_blocked_rdy_low", in_ready, 1'b0);
        chk("ch1_kept", o1, 32'hA1A1A1A1);
        step(2'd3, 32'hC3C3C3C3, 1'b1, 4'b0000, "ch3_past_stall");
        chk("ch13_vld", out_valid, 4'b1010);

        // Drain and refill channel 0 on the same edge
        step(2'd0, 32'h0, 1'b0, 4'b1111, "drain_all");
        step(2'd0, 32'h1, 1'b1, 4'b0000, "c0_fill");
        chk("c0_holds_1", o0, 32'h1);
        step(2'd0, 32'h2, 1'b1, 4'b0001, "c0_swap");
        chk("c0_swap_data", o0, 32'h2);
        chk("c0_swap_vld", out_valid[0], 1'b1);

        // Unknown select and data with in_valid low change nothing
        step(2'd2, 32'h55AA55AA, 1'b1, 4'b0000, "x_prep");
        step(2'bxx, {W{1'bx}}, 1'b0, 4'b0000, "x_idle");
        chk("x_idle_vld", out_valid, 4'b0101);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), "rand");
        end

        // Fill every channel, then reset asynchronously mid-cycle
        for (int k = 0; k < 4; k++) begin
            step(2'(k), 32'hF000_0000 + 32'(k), 1'b1, 4'b0000, "fill");
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_vld", out_valid, 4'b0000);
        chk("arst_o0", o0, 32'h0);
        chk("arst_o1", o1, 32'h0);
        chk("arst_o2", o2, 32'h0);
        chk("arst_o3", o3, 32'h0);
        chk("arst_in_ready", in_ready, 1'b1);
        s        = 2'd1;
        in_data  = 32'h12345678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_no_accept", out_valid, 4'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        step(2'd0, 32'h0, 1'b0, 4'b1111, "post_rst");
        chk("post_rst_vld", out_valid, 4'b0000);

`ifdef DEMUX_CNT_EN
        // 257 deliveries on channel 3 wrap its counter to 1
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 258; i++) begin
            step(2'd3, W'($urandom), 1'b1, 4'b1000, "cnt_run");
        end
        step(2'd0, 32'h0, 1'b0, 4'b0000, "cnt_hold");
        chk("cnt_wrap", cnt, 32'h0100_0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
